// File: rtl/bcd_pkg.sv
// ============================================================================
// bcd_pkg : shared FSM states, iteration/digit counts and a BCD digit check
// Rev 1.0
// ============================================================================
`default_nettype none

package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int ITER       = 10;
    localparam int BCD_DIGITS = 3;

    function automatic logic digit_invalid(input logic [3:0] d);
        return (d > 4'd9);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_corr.sv
// ============================================================================
// bcd_digit_corr : reverse double-dabble digit correction (d >= 8 -> d - 3)
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_digit_corr (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd8) ? (i_digit - 4'd3) : i_digit;

endmodule

`default_nettype wire

// File: rtl/bcd_to_bin.sv
// ============================================================================
// bcd_to_bin : signed 3-digit BCD to W-bit two's-complement, one bit per cycle
// Option macro BCD_TO_BIN_SAT_EN saturates the result on overflow.  Rev 1.0
// ============================================================================
`default_nettype none

module bcd_to_bin #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sign,
    input  logic [3:0]   hundreds,
    input  logic [3:0]   tens,
    input  logic [3:0]   ones,
    output logic         busy,
    output logic [W-1:0] binary,
    output logic         data_ready,
    output logic         overflow,
    output logic         invalid
);

    import bcd_pkg::*;

    localparam int ACC_W = 10;
    localparam int SR_W  = BCD_DIGITS * 4 + ACC_W;

    localparam logic [10:0] c_max_pos = 11'((1 << (W - 1)) - 1);
    localparam logic [10:0] c_max_neg = 11'(1 << (W - 1));

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic [SR_W-1:0]   r_sr;
    logic              r_sign;
    logic              r_bad;
    logic              r_busy;
    logic              r_ready;
    logic [W-1:0]      r_binary;
    logic              r_ovf;
    logic              r_inv;

    logic [SR_W-1:0]   w_shift;
    logic [BCD_DIGITS*4-1:0] w_corr;
    logic [SR_W-1:0]   w_step;
    logic [10:0]       w_mag;
    logic [W-1:0]      w_mag_w;
    logic [W-1:0]      w_twos;
    logic              w_ovf;
    logic [W-1:0]      w_result;

    // Step: shift the whole digit/accumulator register right, then fix digits
    assign w_shift = r_sr >> 1;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_corr
        bcd_digit_corr u_corr (
            .i_digit (w_shift[ACC_W + 4*g +: 4]),
            .o_digit (w_corr[4*g +: 4])
        );
    end

    assign w_step  = {w_corr, w_shift[ACC_W-1:0]};

    assign w_mag   = {1'b0, r_sr[ACC_W-1:0]};
    assign w_mag_w = W'(r_sr[ACC_W-1:0]);
    assign w_twos  = r_sign ? (-w_mag_w) : w_mag_w;

    always_comb begin
        w_ovf    = 1'b0;
        w_result = w_twos;
        if (r_bad) begin
            w_result = '0;
        end else begin
            w_ovf = r_sign ? (w_mag > c_max_neg) : (w_mag > c_max_pos);
`ifdef BCD_TO_BIN_SAT_EN
            if (w_ovf) begin
                w_result = r_sign ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = CONV;
            CONV:    if (r_cnt == 4'(ITER - 1)) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_sr     <= '0;
            r_sign   <= 1'b0;
            r_bad    <= 1'b0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_binary <= '0;
            r_ovf    <= 1'b0;
            r_inv    <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sr   <= {hundreds, tens, ones, {ACC_W{1'b0}}};
                        r_sign <= sign;
                        r_bad  <= digit_invalid(hundreds) | digit_invalid(tens)
                                | digit_invalid(ones);
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                    end
                end
                CONV: begin
                    r_sr  <= w_step;
                    r_cnt <= r_cnt + 4'd1;
                end
                FIN: begin
                    r_binary <= w_result;
                    r_ovf    <= w_ovf;
                    r_inv    <= r_bad;
                    r_ready  <= 1'b1;
                    r_busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy       = r_busy;
    assign binary     = r_binary;
    assign data_ready = r_ready;
    assign overflow   = r_ovf;
    assign invalid    = r_inv;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
// ============================================================================
// tb_bcd_to_bin : directed vectors checked by a queue-based scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bcd_to_bin;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sign;
    logic [3:0]   hundreds;
    logic [3:0]   tens;
    logic [3:0]   ones;
    logic         busy;
    logic [W-1:0] binary;
    logic         data_ready;
    logic         overflow;
    logic         invalid;

    typedef struct {
        logic [W-1:0] bin;
        logic         ov;
        logic         inv;
        int           rdy_cyc;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    bcd_to_bin #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sign       (sign),
        .hundreds   (hundreds),
        .tens       (tens),
        .ones       (ones),
        .busy       (busy),
        .binary     (binary),
        .data_ready (data_ready),
        .overflow   (overflow),
        .invalid    (invalid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every data_ready pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && data_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got data_ready=1 at cycle %0d, expected none", cyc);
            end else begin
                m_e = q.pop_front();
                check("binary",  int'(binary),   int'(m_e.bin));
                check("overflow", int'(overflow), int'(m_e.ov));
                check("invalid",  int'(invalid),  int'(m_e.inv));
                check("latency",  cyc,            m_e.rdy_cyc);
            end
        end
    end

    task automatic convert(input logic s, input logic [3:0] h, input logic [3:0] t,
                           input logic [3:0] o, input logic [W-1:0] eb,
                           input logic eov, input logic einv, input bit push);
        @(negedge clk);
        sign = s; hundreds = h; tens = t; ones = o; start = 1'b1;
        if (push) q.push_back('{eb, eov, einv, cyc + 12});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        check("drain_pending", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},     int'(busy),       0);
        check({tag, "_ready"},    int'(data_ready), 0);
        check({tag, "_binary"},   int'(binary),     0);
        check({tag, "_overflow"}, int'(overflow),   0);
        check({tag, "_invalid"},  int'(invalid),    0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sign = 1'b0;
        hundreds = 4'd0; tens = 4'd0; ones = 4'd0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        convert(1'b0, 4'd0, 4'd4, 4'd5, 8'h2D, 1'b0, 1'b0, 1'b1);
        check("busy_after_start", int'(busy), 1);
        drain();
        check("busy_after_done", int'(busy), 0);

        convert(1'b0, 4'd1, 4'd2, 4'd7, 8'h7F, 1'b0, 1'b0, 1'b1); drain();
        convert(1'b1, 4'd1, 4'd2, 4'd8, 8'h80, 1'b0, 1'b0, 1'b1); drain();
`ifdef BCD_TO_BIN_SAT_EN
        convert(1'b1, 4'd1, 4'd6, 4'd2, 8'h80, 1'b1, 1'b0, 1'b1); drain();
        convert(1'b0, 4'd1, 4'd2, 4'd8, 8'h7F, 1'b1, 1'b0, 1'b1); drain();
        convert(1'b0, 4'd9, 4'd9, 4'd9, 8'h7F, 1'b1, 1'b0, 1'b1); drain();
        convert(1'b1, 4'd1, 4'd2, 4'd9, 8'h80, 1'b1, 1'b0, 1'b1); drain();
`else
        convert(1'b1, 4'd1, 4'd6, 4'd2, 8'h5E, 1'b1, 1'b0, 1'b1); drain();
        convert(1'b0, 4'd1, 4'd2, 4'd8, 8'h80, 1'b1, 1'b0, 1'b1); drain();
        convert(1'b0, 4'd9, 4'd9, 4'd9, 8'hE7, 1'b1, 1'b0, 1'b1); drain();
        convert(1'b1, 4'd1, 4'd2, 4'd9, 8'h7F, 1'b1, 1'b0, 1'b1); drain();
`endif
        convert(1'b0, 4'd0, 4'hA, 4'd0, 8'h00, 1'b0, 1'b1, 1'b1); drain();
        convert(1'b1, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1); drain();
        convert(1'b1, 4'd0, 4'd0, 4'd1, 8'hFF, 1'b0, 1'b0, 1'b1); drain();

        // Result must hold after the pulse
        repeat (5) @(negedge clk);
        check("hold_binary", int'(binary), 8'hFF);

        // start re-pulsed at E5 with different digits must be ignored
        convert(1'b0, 4'd0, 4'd3, 4'd3, 8'h21, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        sign = 1'b0; hundreds = 4'd9; tens = 4'd9; ones = 4'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (20) @(negedge clk);

        // Reset at E6 aborts the conversion without a pulse
        convert(1'b0, 4'd1, 4'd2, 4'd3, 8'h7B, 1'b0, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        convert(1'b0, 4'd0, 4'd9, 4'd9, 8'h63, 1'b0, 1'b0, 1'b1); drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 SHALL have parameter W, default 8, output width in bits; legal range 8..11.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to convert; sampled on the clk rising edge.
REQ-005 SHALL have port sign  input  1  1 = negative magnitude.
REQ-006 SHALL have ports hundreds, tens, ones  input  4 each  BCD digits of the magnitude.
REQ-007 SHALL have port busy  output  1  conversion in progress.
REQ-008 SHALL have port binary  output  W  two's-complement result.
REQ-009 SHALL have port data_ready  output  1  one-cycle pulse when the result is valid.
REQ-010 SHALL have port overflow  output  1  magnitude not representable in W bits.
REQ-011 SHALL have port invalid  output  1  some input digit > 9.

Function
REQ-012 SHALL implement FSM states IDLE, CONV and FIN.
REQ-013 SHALL, in IDLE with start=1 at an edge (E0), latch sign and all digits, clear the iteration counter, set busy=1 and go to CONV.
REQ-014 SHALL, in CONV, perform one reverse double-dabble step per cycle over exactly 10 cycles (E1..E10), then go to FIN.
- Step: shift the {digits, 10-bit accumulator} register right by 1.
- Then subtract 3 from every BCD digit whose value is >= 8.
REQ-015 SHALL, in FIN at E11, register binary, overflow and invalid, set data_ready=1, clear busy and return to IDLE; latency E0->data_ready is 11 cycles.
REQ-016 SHALL hold data_ready high for exactly one cycle; binary, overflow and invalid SHALL hold their values until the next FIN.
REQ-017 SHALL ignore start while busy=1; start sampled at E12 or later SHALL begin a new conversion.
REQ-018 SHALL set invalid=1 and binary=0 when any latched digit > 9; overflow SHALL then be 0.
REQ-019 SHALL set overflow=1 when the positive magnitude exceeds 2^(W-1)-1 or the negative magnitude exceeds 2^(W-1).
REQ-020 SHALL output binary=0 with overflow=0 when sign=1 and magnitude=0.
REQ-021 SHALL, for in-range inputs, output magnitude when sign=0 and its two's-complement negation when sign=1.

Reset
REQ-022 SHALL, while rst=1, force state=IDLE, busy=0, data_ready=0, binary=0, overflow=0, invalid=0, and clear the counter and shift register.
REQ-023 SHALL, on rst assertion mid-conversion, abort the conversion with no data_ready pulse; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-024 SHALL provide macro BCD_TO_BIN_SAT_EN.
- Defined: on overflow, binary saturates to +2^(W-1)-1 (sign=0) or -2^(W-1) (sign=1).
- Undefined: on overflow, binary = low W bits of the wrapped two's-complement result.
- overflow flag behaves identically in both cases.

Structure
REQ-025 SHALL place the FSM state enum, ITER=10 and BCD_DIGITS=3 in shared package bcd_pkg.
REQ-026 SHALL instantiate a 4-bit correction sub-module bcd_digit_corr (if d >= 8 then d-3 else d) once per digit.

Verification
REQ-027 SHALL cover the following scenarios, W=8:
- sign=0, digits 0/4/5, start -> data_ready at 11 cycles, binary=0x2D, overflow=0, invalid=0.
- sign=0, 1/2/7 -> 0x7F; sign=1, 1/2/8 -> 0x80; overflow=0 for both.
- sign=1, 1/6/2:
  - with BCD_TO_BIN_SAT_EN -> binary=0x80, overflow=1.
  - without it -> binary=0x5E, overflow=1.
- tens=0xA -> invalid=1, binary=0, overflow=0.
- start re-pulsed at E5 -> ignored, single data_ready at E11.
- rst asserted at E6 -> all outputs 0, no data_ready; subsequent 0/9/9 -> 0x63.
